cond_check_pipe: RTL and testbench



---
 rtl/cond_pkg.sv | 28 ++
 rtl/cond_flag_gen.sv | 15 +
 rtl/cond_check_pipe.sv | 128 ++++++++++++
 tb/tb_cond_check_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code definitions and the pure evaluator used by the
// condition-check pipeline and its reference model.
package cond_pkg;

    typedef logic [2:0] cond_t;

    localparam cond_t COND_NEVER  = 3'b000;
    localparam cond_t COND_EQZ    = 3'b001;
    localparam cond_t COND_LTZ    = 3'b010;
    localparam cond_t COND_LEZ    = 3'b011;
    localparam cond_t COND_ALWAYS = 3'b100;
    localparam cond_t COND_NEZ    = 3'b101;
    localparam cond_t COND_GEZ    = 3'b110;
    localparam cond_t COND_GTZ    = 3'b111;

    // Upper bit inverts the base test selected by the lower two bits.
    function automatic logic cond_eval(cond_t cond, logic z, logic n);
        logic base;
        case (cond[1:0])
            2'b00:   base = 1'b0;
            2'b01:   base = z;
            2'b10:   base = n;
            default: base = z | n;
        endcase
        return cond[2] ? ~base : base;
    endfunction

endpackage

// File: rtl/cond_flag_gen.sv
// Zero/negative flag generation for a WIDTH-bit operand; N is forced low
// when the operand is unsigned.
module cond_flag_gen #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic [WIDTH-1:0] value,
    output logic             z,
    output logic             n
);

    assign z = (value == '0);
    assign n = (SIGNED != 0) ? value[WIDTH-1] : 1'b0;

endmodule

// File: rtl/cond_check_pipe.sv
// Two-stage valid/ready condition checker: S1 holds flags, S2 is the output
// register; a saturating counter tallies delivered true results.
module cond_check_pipe
    import cond_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [2:0]       in_cond,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] taken_count,
    input  logic             clr_count
);

    logic             in_z;
    logic             in_n;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_z_q,     s1_z_d;
    logic             s1_n_q,     s1_n_d;
    cond_t            s1_cond_q,  s1_cond_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             out_valid_q,  out_valid_d;
    logic             out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic             s2_free;
    logic             s1_move;
    logic             in_fire;
    logic             out_fire;

    cond_flag_gen #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_flags (
        .value (in_value),
        .z     (in_z),
        .n     (in_n)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_move  = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;

        s1_valid_d   = s1_valid_q;
        s1_z_d       = s1_z_q;
        s1_n_d       = s1_n_q;
        s1_cond_d    = s1_cond_q;
        s1_tag_d     = s1_tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        cnt_d        = cnt_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_z_d     = in_z;
            s1_n_d     = in_n;
            s1_cond_d  = in_cond;
            s1_tag_d   = in_tag;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        // Data words stay put when the consumer drains S2 with nothing behind it.
        if (s1_move) begin
            out_valid_d  = 1'b1;
            out_result_d = cond_eval(s1_cond_q, s1_z_q, s1_n_q);
            out_tag_d    = s1_tag_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (out_fire && out_result_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_tag_q    <= '0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: S1 payload is left unreset; it is only ever consumed while s1_valid_q is set.
    always_ff @(posedge clk) begin
        s1_z_q    <= s1_z_d;
        s1_n_q    <= s1_n_d;
        s1_cond_q <= s1_cond_d;
        s1_tag_q  <= s1_tag_d;
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign taken_count = cnt_q;

endmodule

// File: tb/tb_cond_check_pipe.sv
// Bench for cond_check_pipe: scoreboarded signed 8-bit instance plus directed
// checks on an unsigned 2-bit-counter instance and a 16-bit instance.
module tb_cond_check_pipe;
    import cond_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: WIDTH=8 SIGNED=1 TAG_W=4 CNT_W=16
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_result, a_clr;
    logic [7:0]  a_in_value;
    logic [2:0]  a_in_cond;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [15:0] a_taken_count;

    // Instance B: WIDTH=8 SIGNED=0 TAG_W=4 CNT_W=2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_result, b_clr;
    logic [7:0]  b_in_value;
    logic [2:0]  b_in_cond;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [1:0]  b_taken_count;

    // Instance C: WIDTH=16 SIGNED=1 TAG_W=4 CNT_W=16
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_result, c_clr;
    logic [15:0] c_in_value;
    logic [2:0]  c_in_cond;
    logic [3:0]  c_in_tag, c_out_tag;
    logic [15:0] c_taken_count;

    cond_check_pipe #(.WIDTH(8), .SIGNED(1), .TAG_W(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_value(a_in_value), .in_cond(a_in_cond), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .out_tag(a_out_tag), .taken_count(a_taken_count), .clr_count(a_clr)
    );

    cond_check_pipe #(.WIDTH(8), .SIGNED(0), .TAG_W(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_value(b_in_value), .in_cond(b_in_cond), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .out_tag(b_out_tag), .taken_count(b_taken_count), .clr_count(b_clr)
    );

    cond_check_pipe #(.WIDTH(16), .SIGNED(1), .TAG_W(4), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_value(c_in_value), .in_cond(c_in_cond), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_result(c_out_result),
        .out_tag(c_out_tag), .taken_count(c_taken_count), .clr_count(c_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: interpret the raw value as an integer and apply the comparison directly.
    function automatic logic model_result(input logic [2:0] c, input longint v,
                                          input bit sgn, input int w);
        longint sv;
        sv = (sgn && v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return sv == 0;
            3'd2:    return sv < 0;
            3'd3:    return sv <= 0;
            3'd4:    return 1'b1;
            3'd5:    return sv != 0;
            3'd6:    return sv >= 0;
            default: return sv > 0;
        endcase
    endfunction

    typedef struct {
        logic       res;
        logic [3:0] tag;
        int         acc_cyc;
        bit         lat;
    } exp_t;

    exp_t       exp_q[$];
    bit         mon_en = 1'b0;
    bit         lat_mode = 1'b0;
    int         cyc = 0;
    int         pops = 0;
    int         model_cnt = 0;
    bit         prev_stall = 1'b0;
    logic       prev_res;
    logic [3:0] prev_tag;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("a_taken_count", 32'(a_taken_count), 32'(model_cnt));
            if (prev_stall) begin
                check("a_hold_valid", 32'(a_out_valid), 32'd1);
                check("a_hold_result", 32'(a_out_result), 32'(prev_res));
                check("a_hold_tag", 32'(a_out_tag), 32'(prev_tag));
            end
            if (rst) begin
                exp_q.delete();
                model_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL a_spurious: got result tag %0h, expected no result", a_out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        check("a_result", 32'(a_out_result), 32'(e.res));
                        check("a_tag", 32'(a_out_tag), 32'(e.tag));
                        if (e.lat) check("a_latency", 32'(cyc - e.acc_cyc), 32'd2);
                    end
                end
                if (a_clr) model_cnt = 0;
                else if (a_out_valid && a_out_ready && a_out_result === 1'b1 && model_cnt < 65535)
                    model_cnt++;
                if (a_in_valid && a_in_ready) begin
                    e.res     = model_result(a_in_cond, longint'(a_in_value), 1'b1, 8);
                    e.tag     = a_in_tag;
                    e.acc_cyc = cyc;
                    e.lat     = lat_mode;
                    exp_q.push_back(e);
                end
                prev_stall = a_out_valid && !a_out_ready;
                prev_res   = a_out_result;
                prev_tag   = a_out_tag;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
    task automatic a_drive(input logic [7:0] v, input logic [2:0] c, input logic [3:0] t);
        bit acc = 1'b0;
        int guard = 0;
        a_in_valid = 1'b1;
        a_in_value = v;
        a_in_cond  = c;
        a_in_tag   = t;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_accept_timeout: got in_ready=0 for %0d cycles, expected accept", guard);
        end
    endtask

    task automatic send_b(input logic [7:0] v, input logic [2:0] c, input logic [3:0] t,
                          input logic exp, input bit clr_at_out);
        b_in_valid = 1'b1;
        b_in_value = v;
        b_in_cond  = c;
        b_in_tag   = t;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        check("b_valid", 32'(b_out_valid), 32'd1);
        check("b_result", 32'(b_out_result), 32'(exp));
        check("b_tag", 32'(b_out_tag), 32'(t));
        b_clr = clr_at_out;
        @(posedge clk); #1;
        b_clr = 1'b0;
    endtask

    task automatic send_c(input logic [15:0] v, input logic [2:0] c, input logic [3:0] t,
                          input logic exp);
        c_in_valid = 1'b1;
        c_in_value = v;
        c_in_cond  = c;
        c_in_tag   = t;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(posedge clk); #1;
        check("c_valid", 32'(c_out_valid), 32'd1);
        check("c_result", 32'(c_out_result), 32'(exp));
        check("c_tag", 32'(c_out_tag), 32'(t));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] vals [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        int         b_exp_cnt [5] = '{1, 2, 3, 3, 3};
        logic [3:0] tag = 4'd0;
        int         pops_before;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_value = '0; a_in_cond = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_in_value = '0; b_in_cond = '0; b_in_tag = '0;
        c_in_valid = 1'b0; c_in_value = '0; c_in_cond = '0; c_in_tag = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_result", 32'(a_out_result), 32'd0);
        check("rst_out_tag", 32'(a_out_tag), 32'd0);
        check("rst_taken", 32'(a_taken_count), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);

        check("pin_ltz_80", 32'(model_result(COND_LTZ, 64'h80, 1'b1, 8)), 32'd1);
        check("pin_gtz_ff", 32'(model_result(COND_GTZ, 64'hFF, 1'b1, 8)), 32'd0);
        check("pin_gez_80u", 32'(model_result(COND_GEZ, 64'h80, 1'b0, 8)), 32'd1);
        check("pin_lez_7f", 32'(model_result(COND_LEZ, 64'h7F, 1'b1, 8)), 32'd0);
        check("pin_eval_nez", 32'(cond_eval(COND_NEZ, 1'b1, 1'b0)), 32'd0);
        mon_en = 1'b1;

        // Full sweep at one request per cycle.
        lat_mode = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 5; i++) begin
                a_drive(vals[i], 3'(c), tag);
                tag = tag + 4'd1;
            end
        end
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stream_taken", 32'(a_taken_count), 32'd20);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_pops", 32'(pops), 32'd40);

        // Backpressure: two accepts fill the pipe, the third waits.
        lat_mode = 1'b0;
        pops_before = pops;
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_value = 8'h05; a_in_cond = COND_ALWAYS; a_in_tag = 4'hA;
        check("bp_ready0", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_value = 8'h00; a_in_cond = COND_EQZ; a_in_tag = 4'hB;
        check("bp_ready1", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_value = 8'h80; a_in_cond = COND_NEVER; a_in_tag = 4'hC;
        check("bp_ready2", 32'(a_in_ready), 32'd0);
        check("bp_head_tag", 32'(a_out_tag), 32'hA);
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_hold", 32'(a_in_ready), 32'd0);
        check("bp_head_hold", 32'(a_out_tag), 32'hA);
        a_out_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_pops", 32'(pops - pops_before), 32'd3);
        check("bp_taken", 32'(a_taken_count), 32'd22);

        // Clear while a taken result hands off.
        a_drive(8'h01, COND_NEZ, 4'h3);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        check("a_clr_taken", 32'(a_taken_count), 32'd0);

        // Reset with both stages full.
        a_out_ready = 1'b0;
        a_drive(8'hFF, COND_LTZ, 4'h6);
        a_drive(8'h01, COND_GTZ, 4'h7);
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_out_valid", 32'(a_out_valid), 32'd0);
        check("mrst_taken", 32'(a_taken_count), 32'd0);
        check("mrst_in_ready", 32'(a_in_ready), 32'd1);
        rst = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mrst_no_stale", 32'(a_out_valid), 32'd0);

        // Unsigned instance and 2-bit saturating counter.
        send_b(8'h80, COND_LTZ, 4'h1, 1'b0, 1'b0);
        send_b(8'h80, COND_GEZ, 4'h2, 1'b1, 1'b0);
        send_b(8'h80, COND_GTZ, 4'h3, 1'b1, 1'b0);
        send_b(8'h00, COND_LEZ, 4'h4, 1'b1, 1'b0);
        check("b_taken_sat3", 32'(b_taken_count), 32'd3);
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        check("b_clr", 32'(b_taken_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_b(8'h00, COND_ALWAYS, 4'(i), 1'b1, 1'b0);
            check("b_sat_seq", 32'(b_taken_count), 32'(b_exp_cnt[i]));
        end
        send_b(8'h00, COND_ALWAYS, 4'h9, 1'b1, 1'b1);
        check("b_clr_priority", 32'(b_taken_count), 32'd0);

        // 16-bit signed instance.
        send_c(16'h8000, COND_LTZ, 4'h1, 1'b1);
        send_c(16'h0001, COND_GTZ, 4'h2, 1'b1);
        send_c(16'h0000, COND_NEZ, 4'h3, 1'b0);
        send_c(16'h8000, COND_GTZ, 4'h4, 1'b0);
        check("c_taken", 32'(c_taken_count), 32'd2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
